// File: rtl/rv_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Holds the instruction format encoding, a few opcode constants, the
// canonical NOP word and the signed immediate range limits.
package rv_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    // addi x0, x0, 0 -- emitted in place of any word whose fields are bad
    localparam logic [31:0] INSTR_NOP = 32'h00000013;

    // Inclusive signed ranges of the datapath immediate for each format
    localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX =  32'sd2047;
    localparam logic signed [31:0] IMMB_MIN  = -32'sd4096;
    localparam logic signed [31:0] IMMB_MAX  =  32'sd4094;
    localparam logic signed [31:0] IMMJ_MIN  = -32'sd1048576;
    localparam logic signed [31:0] IMMJ_MAX  =  32'sd1048574;

endpackage

// File: rtl/instr_encoder_imm_scatter.sv
// imm_scatter: purely combinational packer for one RV32I instruction.
// Range-checks the signed immediate for the given format, scatters its
// bits into the ISA positions and substitutes a NOP when the fields are
// unusable (out-of-range, misaligned, or an illegal format code).
module imm_scatter
    import rv_enc_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output logic        err_o
);

    logic signed [31:0] immS;
    logic [31:0]        rawWord;
    logic               fieldErr;

    assign immS = $signed(imm_i);

    // Pack the fields for the selected format and flag unencodable immediates
    always_comb begin
        rawWord  = '0;
        fieldErr = 1'b0;
        case (fmt_i)
            FMT_R: begin
                rawWord = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            FMT_I: begin
                rawWord  = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                fieldErr = (immS < IMM12_MIN) || (immS > IMM12_MAX);
            end
            FMT_S: begin
                rawWord  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                fieldErr = (immS < IMM12_MIN) || (immS > IMM12_MAX);
            end
            FMT_B: begin
                rawWord  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], opcode_i};
                fieldErr = (immS < IMMB_MIN) || (immS > IMMB_MAX) || imm_i[0];
            end
            FMT_U: begin
                rawWord  = {imm_i[31:12], rd_i, opcode_i};
                fieldErr = (imm_i[11:0] != 12'd0);
            end
            FMT_J: begin
                rawWord  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                fieldErr = (immS < IMMJ_MIN) || (immS > IMMJ_MAX) || imm_i[0];
            end
            default: begin
                fieldErr = 1'b1;
            end
        endcase
    end

    assign err_o   = fieldErr;
    assign instr_o = fieldErr ? INSTR_NOP : rawWord;

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: two-stage streaming RV32I instruction encoder.
// S1 captures the decoded fields, imm_scatter packs them and flags errors,
// S2 holds the finished word together with its byte address in instruction
// memory. Valid/ready on both sides; throughput one word per cycle.
// Optional macro INSTR_ENC_ERR_CNT_EN adds a saturating 16-bit count of
// errored words delivered (port err_cnt).
module instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int                ADDR_W     = 10,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
`ifdef INSTR_ENC_ERR_CNT_EN
    ,
    output logic [15:0]       err_cnt
`endif
);

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

    logic        s1Valid_q;
    logic [2:0]  s1Fmt_q;
    logic [6:0]  s1Opcode_q;
    logic [4:0]  s1Rd_q;
    logic [4:0]  s1Rs1_q;
    logic [4:0]  s1Rs2_q;
    logic [2:0]  s1Funct3_q;
    logic [6:0]  s1Funct7_q;
    logic [31:0] s1Imm_q;

    logic        s2Valid_q;
    logic [31:0] s2Instr_q;
    logic        s2Err_q;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    logic        s1Adv;
    logic        s2Adv;
    logic        outFire;
    logic [31:0] packedInstr;
    logic        packedErr;

    // A stage may load when it is empty or its content leaves this cycle
    assign s2Adv    = !s2Valid_q || out_ready;
    assign s1Adv    = !s1Valid_q || s2Adv;
    assign in_ready = s1Adv;
    assign outFire  = s2Valid_q && out_ready;

    // S1: capture the request fields on an input handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1Valid_q  <= 1'b0;
            s1Fmt_q    <= '0;
            s1Opcode_q <= '0;
            s1Rd_q     <= '0;
            s1Rs1_q    <= '0;
            s1Rs2_q    <= '0;
            s1Funct3_q <= '0;
            s1Funct7_q <= '0;
            s1Imm_q    <= '0;
        end else if (s1Adv) begin
            s1Valid_q <= in_valid;
            if (in_valid) begin
                s1Fmt_q    <= in_fmt;
                s1Opcode_q <= in_opcode;
                s1Rd_q     <= in_rd;
                s1Rs1_q    <= in_rs1;
                s1Rs2_q    <= in_rs2;
                s1Funct3_q <= in_funct3;
                s1Funct7_q <= in_funct7;
                s1Imm_q    <= in_imm;
            end
        end
    end

    imm_scatter u_imm_scatter (
        .fmt_i    (s1Fmt_q),
        .opcode_i (s1Opcode_q),
        .rd_i     (s1Rd_q),
        .rs1_i    (s1Rs1_q),
        .rs2_i    (s1Rs2_q),
        .funct3_i (s1Funct3_q),
        .funct7_i (s1Funct7_q),
        .imm_i    (s1Imm_q),
        .instr_o  (packedInstr),
        .err_o    (packedErr)
    );

    // S2: hold the packed word; contents freeze while the consumer stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2Valid_q <= 1'b0;
            s2Instr_q <= '0;
            s2Err_q   <= 1'b0;
        end else if (s2Adv) begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                s2Instr_q <= packedInstr;
                s2Err_q   <= packedErr;
            end
        end
    end

    // Next word address: step one word per delivered instruction, wrapping freely
    always_comb begin
        addr_d = addr_q;
        if (outFire) begin
            addr_d = addr_q + ADDR_STEP;
        end
    end

    // Address of the word currently presented at the output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= RESET_ADDR;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign out_valid = s2Valid_q;
    assign out_instr = s2Instr_q;
    assign out_err   = s2Err_q;
    assign out_addr  = addr_q;

`ifdef INSTR_ENC_ERR_CNT_EN
    logic [15:0] errCnt_q;
    logic [15:0] errCnt_d;

    // Count delivered errored words, sticking at all-ones
    always_comb begin
        errCnt_d = errCnt_q;
        if (outFire && s2Err_q && (errCnt_q != 16'hFFFF)) begin
            errCnt_d = errCnt_q + 16'd1;
        end
    end

    // Error counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errCnt_q <= '0;
        end else begin
            errCnt_q <= errCnt_d;
        end
    end

    assign err_cnt = errCnt_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a table of directed single-word
// vectors with hand-computed encodings, followed by hand-written sequences
// for backpressure, reset with words in flight and (with
// INSTR_ENC_ERR_CNT_EN) the error counter.
module tb_instr_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [9:0]  out_addr;
    logic        out_err;
`ifdef INSTR_ENC_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    typedef struct {
        string       name;
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] expInstr;
        logic        expErr;
    } vec_t;

    vec_t vecs[$];

    int          testsRun  = 0;
    int          failCount = 0;
    logic [9:0]  expAddr   = 10'd0;

    instr_encoder #(
        .ADDR_W     (10),
        .RESET_ADDR (10'd0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_err   (out_err)
`ifdef INSTR_ENC_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void addVec(string n, logic [2:0] f, logic [6:0] op,
                                   logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                   logic [2:0] f3, logic [6:0] f7, logic [31:0] imm,
                                   logic [31:0] ei, logic ee);
        vec_t v;
        v.name = n; v.fmt = f; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.f3 = f3; v.f7 = f7; v.imm = imm; v.expInstr = ei; v.expErr = ee;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic driveFields(input vec_t v);
        in_fmt    = v.fmt;
        in_opcode = v.op;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct3 = v.f3;
        in_funct7 = v.f7;
        in_imm    = v.imm;
    endtask

    // Send one word into an idle encoder with out_ready high, then check
    // its latency, encoding, error flag and address
    task automatic applyStimulus(input vec_t v);
        int   lat;
        logic seen;
        @(negedge clk);
        driveFields(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 8) begin
            @(negedge clk);
            lat++;
            if (out_valid) seen = 1'b1;
        end
        checkOutput({v.name, " latency"}, 32'(lat), 32'd2);
        checkOutput({v.name, " instr"}, out_instr, v.expInstr);
        checkOutput({v.name, " err"}, {31'd0, out_err}, {31'd0, v.expErr});
        checkOutput({v.name, " addr"}, {22'd0, out_addr}, {22'd0, expAddr});
        if (seen) begin
            @(posedge clk);
            #1;
            expAddr = expAddr + 10'd4;
        end
    endtask

    task automatic resetPulse();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        expAddr = 10'd0;
    endtask

    function automatic vec_t addiVec(string n, int k);
        vec_t v;
        v.name = n; v.fmt = 3'd1; v.op = 7'h13; v.rd = 5'd1; v.rs1 = 5'd0;
        v.rs2 = 5'd0; v.f3 = 3'd0; v.f7 = 7'd0; v.imm = 32'(k);
        v.expInstr = (32'(k) << 20) | 32'h00000093;
        v.expErr = 1'b0;
        return v;
    endfunction

    initial begin
        int   sent;
        int   got;
        int   cyc;
        logic acc;
        vec_t v;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        driveFields(addiVec("idle", 0));

        //      name          fmt  op      rd  rs1 rs2 f3  f7      imm            instr          err
        addVec("addi_x1_15",  1, 7'h13,  1,  0,  0,  0, 7'h00, 32'h0000000F, 32'h00F00093, 0);
        addVec("beq_m4096",   3, 7'h63,  0,  0,  0,  0, 7'h00, 32'hFFFFF000, 32'h80000063, 0);
        addVec("beq_odd",     3, 7'h63,  0,  0,  0,  0, 7'h00, 32'h00000003, 32'h00000013, 1);
        addVec("jal_2",       5, 7'h6F,  1,  0,  0,  0, 7'h00, 32'h00000002, 32'h002000EF, 0);
        addVec("jal_2p20",    5, 7'h6F,  1,  0,  0,  0, 7'h00, 32'h00100000, 32'h00000013, 1);
        addVec("lui_x5",      4, 7'h37,  5,  0,  0,  0, 7'h00, 32'hABCDE000, 32'hABCDE2B7, 0);
        addVec("lui_lowbits", 4, 7'h37,  5,  0,  0,  0, 7'h00, 32'hABCDE001, 32'h00000013, 1);
        addVec("sub_r",       0, 7'h33,  3,  1,  2,  0, 7'h20, 32'hDEADBEEF, 32'h402081B3, 0);
        addVec("sw_m4",       2, 7'h23,  0,  1,  2,  2, 7'h00, 32'hFFFFFFFC, 32'hFE20AE23, 0);
        addVec("addi_2047",   1, 7'h13,  0,  0,  0,  0, 7'h00, 32'h000007FF, 32'h7FF00013, 0);
        addVec("addi_2048",   1, 7'h13,  0,  0,  0,  0, 7'h00, 32'h00000800, 32'h00000013, 1);
        addVec("addi_m2048",  1, 7'h13,  0,  0,  0,  0, 7'h00, 32'hFFFFF800, 32'h80000013, 0);
        addVec("sw_m2049",    2, 7'h23,  0,  1,  2,  2, 7'h00, 32'hFFFFF7FF, 32'h00000013, 1);
        addVec("beq_4094",    3, 7'h63,  0,  0,  0,  0, 7'h00, 32'h00000FFE, 32'h7E000FE3, 0);
        addVec("beq_4096",    3, 7'h63,  0,  0,  0,  0, 7'h00, 32'h00001000, 32'h00000013, 1);
        addVec("jal_min",     5, 7'h6F,  0,  0,  0,  0, 7'h00, 32'hFFF00000, 32'h8000006F, 0);
        addVec("jal_max",     5, 7'h6F,  0,  0,  0,  0, 7'h00, 32'h000FFFFE, 32'h7FFFF06F, 0);
        addVec("jal_below",   5, 7'h6F,  0,  0,  0,  0, 7'h00, 32'hFFEFFFFE, 32'h00000013, 1);
        addVec("fmt6",        6, 7'h13,  1,  0,  0,  0, 7'h00, 32'h00000000, 32'h00000013, 1);
        addVec("fmt7",        7, 7'h13,  1,  0,  0,  0, 7'h00, 32'h00000000, 32'h00000013, 1);
        addVec("lui_zero",    4, 7'h37,  0,  0,  0,  0, 7'h00, 32'h00000000, 32'h00000037, 0);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset out_instr", out_instr, 32'd0);
        checkOutput("reset out_err", {31'd0, out_err}, 32'd0);
        checkOutput("reset out_addr", {22'd0, out_addr}, 32'd0);
        checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
`ifdef INSTR_ENC_ERR_CNT_EN
        checkOutput("reset err_cnt", {16'd0, err_cnt}, 32'd0);
`endif

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
        end

        // Reset with two words in flight: output must vanish at once and the
        // address must restart from the reset value
        @(negedge clk);
        out_ready = 1'b0;
        driveFields(addiVec("rst_a", 7));
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        driveFields(addiVec("rst_b", 8));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checkOutput("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("pre-reset out_addr", {22'd0, out_addr}, {22'd0, expAddr});
        reset = 1'b1;
        #1;
        checkOutput("mid-reset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid-reset out_addr", {22'd0, out_addr}, 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        expAddr = 10'd0;
        @(negedge clk);
        checkOutput("post-reset no stale word", {31'd0, out_valid}, 32'd0);
        applyStimulus(addiVec("post_reset_addi", 21));

        // Backpressure: four back-to-back words, consumer stalled 3 cycles
        resetPulse();
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 4 && cyc < 40) begin
            @(negedge clk);
            out_ready = (cyc >= 3);
            if (sent < 4) begin
                driveFields(addiVec("bp", sent + 1));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 2) begin
                checkOutput("bp in_ready low when full", {31'd0, in_ready}, 32'd0);
                checkOutput("bp accepts before stall", 32'(sent), 32'd2);
                checkOutput("bp stalled instr", out_instr, 32'h00100093);
            end
            if (out_valid && out_ready) begin
                checkOutput("bp order instr", out_instr,
                            (32'(got + 1) << 20) | 32'h00000093);
                checkOutput("bp order addr", {22'd0, out_addr}, {22'd0, expAddr});
                expAddr = expAddr + 10'd4;
                got++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) sent++;
            cyc++;
        end
        checkOutput("bp words delivered", 32'(got), 32'd4);
        checkOutput("bp words accepted", 32'(sent), 32'd4);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bp no duplicate", {31'd0, out_valid}, 32'd0);

`ifdef INSTR_ENC_ERR_CNT_EN
        // Error counter: three errored words, one clean word, then reset
        resetPulse();
        applyStimulus(vecs[2]);
        applyStimulus(vecs[10]);
        applyStimulus(vecs[19]);
        checkOutput("err_cnt after 3 errors", {16'd0, err_cnt}, 32'd3);
        applyStimulus(vecs[0]);
        checkOutput("err_cnt clean word", {16'd0, err_cnt}, 32'd3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("err_cnt cleared by reset", {16'd0, err_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
